// File: rtl/digit_slot_display_ctrl.sv
// Four-slot two-digit card display scheduler for a shared segment renderer.
// Card values are double-buffered and swapped in at frame start.
module digit_slot_display_ctrl #(
  parameter int X0           = 100,
  parameter int Y0           = 60,
  parameter int SLOT_PITCH   = 260,
  parameter int ROW_PITCH    = 200,
  parameter int DIGIT_PITCH  = 90,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  input  logic       de,
  input  logic       frame_start,
  input  logic       wr_valid,
  input  logic [1:0] wr_slot,
  input  logic [3:0] wr_value,
  output logic       wr_ready,
  input  logic       cursor_en,
  input  logic [1:0] cursor_slot,
  output logic [9:0] rd_sx_offset,
  output logic [9:0] rd_sy_offset,
  output logic [3:0] rd_number,
  output logic       rd_hit,
  input  logic       rd_display,
  output logic       pixel_on
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    COMMIT
  } state_t;

  state_t          state;
  logic [3:0]      shadow [4];
  logic [3:0]      active [4];
  logic [CW-1:0]   frame_cnt;
  logic            blink_phase;

  logic            hit_c;
  logic [3:0]      num_c;
  logic [9:0]      dx_c;
  logic [9:0]      dy_c;
  logic [9:0]      ox;
  logic [9:0]      oy;
  logic [9:0]      dx;
  logic [9:0]      dy;
  logic [3:0]      v;
  logic [3:0]      dig;
  logic            show;
  logic            hide;

  // Offsets wrap mod 1024 when left of/above a box, so one compare covers both sides.
  always_comb begin
    hit_c = 1'b0;
    num_c = '0;
    dx_c  = '0;
    dy_c  = '0;
    ox    = '0;
    oy    = '0;
    dx    = '0;
    dy    = '0;
    v     = '0;
    dig   = '0;
    show  = 1'b0;
    hide  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      v    = active[k];
      hide = cursor_en && (cursor_slot == 2'(k)) && blink_phase;
      oy   = 10'(Y0 + (k / 2) * ROW_PITCH);
      dy   = sy - oy;
      for (int d = 0; d < 2; d++) begin
        ox   = 10'(X0 + (k % 2) * SLOT_PITCH + d * DIGIT_PITCH);
        dx   = sx - ox;
        show = (d == 0) ? (v >= 4'd10 && v <= 4'd13)
                        : (v >= 4'd1 && v <= 4'd13);
        dig  = (d == 0) ? 4'd1
                        : ((v >= 4'd10) ? v - 4'd10 : v);
        if (de && show && !hide &&
            dx <= 10'd80 && dy <= 10'd140) begin
          hit_c = 1'b1;
          num_c = dig;
          dx_c  = dx;
          dy_c  = dy;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ready     <= 1'b1;
      for (int k = 0; k < 4; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      frame_cnt    <= '0;
      blink_phase  <= 1'b0;
      rd_hit       <= 1'b0;
      rd_number    <= '0;
      rd_sx_offset <= '0;
      rd_sy_offset <= '0;
      pixel_on     <= 1'b0;
    end else begin
      rd_hit       <= hit_c;
      rd_number    <= num_c;
      rd_sx_offset <= dx_c;
      rd_sy_offset <= dy_c;
      pixel_on     <= rd_hit && rd_display;

      if (frame_start) begin
        if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (wr_valid) begin
            shadow[wr_slot] <= wr_value;
            state           <= PEND;
          end
        end
        PEND: begin
          if (wr_valid) shadow[wr_slot] <= wr_value;
          if (frame_start) begin
            state    <= COMMIT;
            wr_ready <= 1'b0;
          end
        end
        COMMIT: begin
          for (int k = 0; k < 4; k++) active[k] <= shadow[k];
          state    <= IDLE;
          wr_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          wr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_slot_display_ctrl.sv
// Bench for digit_slot_display_ctrl: directed steps then random traffic,
// checked against a slot/frame level model of the card display.
module tb_digit_slot_display_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       de;
  logic       frame_start;
  logic       wr_valid;
  logic [1:0] wr_slot;
  logic [3:0] wr_value;
  logic       wr_ready;
  logic       cursor_en;
  logic [1:0] cursor_slot;
  logic [9:0] rd_sx_offset;
  logic [9:0] rd_sy_offset;
  logic [3:0] rd_number;
  logic       rd_hit;
  logic       rd_display;
  logic       pixel_on;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  digit_slot_display_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .sx           (sx),
    .sy           (sy),
    .de           (de),
    .frame_start  (frame_start),
    .wr_valid     (wr_valid),
    .wr_slot      (wr_slot),
    .wr_value     (wr_value),
    .wr_ready     (wr_ready),
    .cursor_en    (cursor_en),
    .cursor_slot  (cursor_slot),
    .rd_sx_offset (rd_sx_offset),
    .rd_sy_offset (rd_sy_offset),
    .rd_number    (rd_number),
    .rd_hit       (rd_hit),
    .rd_display   (rd_display),
    .pixel_on     (pixel_on)
  );

  // Stand-in renderer: an arbitrary pattern of the request fields.
  function automatic logic stub(input logic [9:0] ox, oy,
                                input logic [3:0] n);
    return ox[2] ^ oy[3] ^ n[0];
  endfunction

  assign rd_display = stub(rd_sx_offset, rd_sy_offset, rd_number);

  // Reference model state
  int  m_shadow [4];
  int  m_active [4];
  bit  m_dirty;
  bit  m_commit;
  int  m_frames;
  logic       p_hit;
  logic [3:0] p_num;
  logic [9:0] p_ox;
  logic [9:0] p_oy;

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_shadow[k] = 0;
      m_active[k] = 0;
    end
    m_dirty  = 0;
    m_commit = 0;
    m_frames = 0;
  endfunction

  function automatic void model_rd(input int x, input int y, input bit d,
                                   output logic h, output logic [3:0] n,
                                   output logic [9:0] ox, output logic [9:0] oy);
    h = 0; n = 0; ox = 0; oy = 0;
    for (int k = 0; k < 4; k++) begin
      int val = m_active[k];
      bit hidden = cursor_en && (int'(cursor_slot) == k) &&
                   ((m_frames / 30) % 2 == 1);
      int by = 60 + (k / 2) * 200;
      if (hidden || val == 0 || val > 13) continue;
      for (int pos = 0; pos < 2; pos++) begin
        int bx = 100 + (k % 2) * 260 + pos * 90;
        if (pos == 0 && val < 10) continue;
        if (d && x >= bx && x <= bx + 80 && y >= by && y <= by + 140) begin
          h  = 1;
          n  = (pos == 0) ? 4'd1 : 4'(val % 10);
          ox = 10'(x - bx);
          oy = 10'(y - by);
        end
      end
    end
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit fs, input bit wv,
                      input int ws, input int wval,
                      input int x, input int y, input bit d);
    logic       e_hit;
    logic [3:0] e_num;
    logic [9:0] e_ox;
    logic [9:0] e_oy;
    logic       e_pix;
    bit         acc;
    rst         = r;
    frame_start = fs;
    wr_valid    = wv;
    wr_slot     = 2'(ws);
    wr_value    = 4'(wval);
    sx          = 10'(x);
    sy          = 10'(y);
    de          = d;
    if (r) begin
      e_hit = 0; e_num = 0; e_ox = 0; e_oy = 0; e_pix = 0;
    end else begin
      model_rd(x, y, d, e_hit, e_num, e_ox, e_oy);
      e_pix = p_hit && stub(p_ox, p_oy, p_num);
    end
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      acc = wv && !m_commit;
      if (m_commit) begin
        for (int k = 0; k < 4; k++) m_active[k] = m_shadow[k];
        m_commit = 0;
      end else begin
        if (acc) m_shadow[ws] = wval;
        if (m_dirty && fs) begin
          m_commit = 1;
          m_dirty  = 0;
        end else if (acc) begin
          m_dirty = 1;
        end
      end
      if (fs) m_frames++;
    end
    check("rd_hit", rd_hit, e_hit);
    check("rd_number", rd_number, e_num);
    check("rd_sx_offset", rd_sx_offset, e_ox);
    check("rd_sy_offset", rd_sy_offset, e_oy);
    check("pixel_on", pixel_on, e_pix);
    check("wr_ready", wr_ready, !m_commit);
    p_hit = e_hit; p_num = e_num; p_ox = e_ox; p_oy = e_oy;
  endtask

  task automatic px(input int x, input int y);
    step(0, 0, 0, 0, 0, x, y, 1);
  endtask

  task automatic wr(input int s, input int v);
    step(0, 0, 1, s, v, 300, 300, 1);
  endtask

  task automatic frame();
    step(0, 1, 0, 0, 0, 0, 0, 1);
    px(1, 0);
  endtask

  initial begin
    p_hit = 0; p_num = 0; p_ox = 0; p_oy = 0;
    cursor_en   = 0;
    cursor_slot = 0;
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    px(110, 70);

    // Pending write discarded by reset
    wr(1, 5);
    px(460, 70);
    step(1, 0, 0, 0, 0, 460, 70, 1);
    frame();
    px(460, 70);
    px(370, 70);
    frame();
    px(460, 70);

    // Slot 0 = 12 written mid-frame
    wr(0, 12);
    px(110, 70);
    frame();
    px(110, 70);
    px(200, 70);
    px(5, 5);

    // Slot 3 = 7 box edges
    wr(3, 7);
    frame();
    px(360, 260);
    px(450, 260);
    px(531, 401);
    px(531, 402);
    step(0, 0, 0, 0, 0, 450, 260, 0);
    px(449, 260);

    // Write in frame_start cycle and write held across COMMIT
    wr(2, 6);
    step(0, 1, 1, 1, 8, 0, 0, 1);
    step(0, 0, 1, 0, 9, 1, 0, 1);
    step(0, 0, 1, 0, 9, 2, 0, 1);
    px(195, 270);
    px(460, 70);
    px(190, 70);
    frame();
    px(190, 70);

    // Blink of slot 0, slot 1 unaffected
    step(1, 0, 0, 0, 0, 0, 0, 0);
    wr(0, 3);
    wr(1, 4);
    cursor_en   = 1;
    cursor_slot = 0;
    for (int f = 0; f < 65; f++) begin
      frame();
      px(190, 70);
      px(450, 70);
    end
    cursor_slot = 1;
    px(450, 70);
    cursor_en = 0;
    px(190, 70);

    // Blank values and last-write-wins
    wr(0, 0);
    wr(1, 14);
    wr(3, 15);
    wr(2, 4);
    wr(2, 9);
    frame();
    px(190, 70);
    px(450, 70);
    px(360, 260);
    px(450, 260);
    px(195, 270);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        cursor_en   = 1'($urandom);
        cursor_slot = 2'($urandom);
      end
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3),
           $urandom_range(0, 15),
           $urandom_range(0, 639),
           $urandom_range(0, 479),
           $urandom_range(0, 7) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
